button_debouncer: RTL



---
 rtl/button_debouncer.sv | 105 ++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, bounce filter and a one-cycle
// delayed copy of the clean level for a downstream rising-edge comparator.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic level_prev,
  output logic settling
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             synced;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             settling_nxt;

  // raw_in is only ever sampled here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_in};
    end
  end

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      settling   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level      <= level_nxt;
      level_prev <= level;
      settling   <= settling_nxt;
    end
  end

  // A bounce back to the held value always wins over a completed count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      LOW: begin
        if (synced) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!synced) begin
          state_nxt = LOW;
        end else if (cnt == CNT_DONE) begin
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!synced) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (synced) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_DONE) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
      end
    endcase

    level_nxt    = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
    settling_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule
